// File: rtl/pgr_fft_ctrl_mc.sv
// Multi-channel FFT frame controller: per-channel length/mode config, frame sequencing IDLE/CFG/LOAD/CALC/OUT.
// Optional macro FFT_CTRL_LEN_CHK_EN adds beat-count length checking and the len_err output.
`timescale 1ns/1ps
module pgr_fft_ctrl_mc #(
    parameter int NUM_CH     = 2,
    parameter int LEN_WIDTH  = 16,
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_MODE   = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [23:0]          cfg_data,
    output logic                 cfg_ready,
    input  logic                 s_axi_valid,
    input  logic                 s_axi_last,
    input  logic [CH_W-1:0]      s_axi_tid,
    output logic                 s_axi_ready,
    output logic                 dft_mode,
    output logic [LEN_WIDTH-1:0] dft_length,
    output logic [3:0]           fft_lev_limit,
    output logic [CH_W-1:0]      fft_ch,
    input  logic                 fft_cdone,
    input  logic                 fft_odone,
    output logic                 fft_idone,
    output logic                 busy
`ifdef FFT_CTRL_LEN_CHK_EN
    ,output logic                len_err
`endif
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_CFG  = 5'b00010,
        S_LOAD = 5'b00100,
        S_CALC = 5'b01000,
        S_OUT  = 5'b10000
    } state_t;

    // floor(log2(len)) clamped to 3..15; a zero length stands for 2^LEN_WIDTH
    function automatic logic [3:0] lev_of(input logic [LEN_WIDTH-1:0] len);
        int msb;
        msb = LEN_WIDTH;
        for (int i = 0; i < LEN_WIDTH; i++) begin
            if (len[i]) msb = i;
        end
        if (msb < 3)  msb = 3;
        if (msb > 15) msb = 15;
        return 4'(msb);
    endfunction

    localparam logic [LEN_WIDTH-1:0] RST_LEN  = LEN_WIDTH'(FFT_LENGTH);
    localparam logic                 RST_MODE = (FFT_MODE != 0);
    localparam logic [3:0]           RST_LEV  = lev_of(RST_LEN);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cfg_len_q  [NUM_CH];
    logic [LEN_WIDTH-1:0]   cfg_len_d  [NUM_CH];
    logic                   cfg_mode_q [NUM_CH];
    logic                   cfg_mode_d [NUM_CH];
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   mode_q, mode_d;
    logic [3:0]             lev_q, lev_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [LEN_WIDTH:0]     cnt_q, cnt_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   s_ready_q, s_ready_d;
    logic                   idone_q, idone_d;
    logic                   busy_q, busy_d;
    logic                   beat_acc;
    logic [CH_W-1:0]        tid_sel;
    logic [5:0]             cfg_idx;
`ifdef FFT_CTRL_LEN_CHK_EN
    logic                   err_q, err_d;
    logic [LEN_WIDTH+1:0]   cnt_nxt;
    logic [LEN_WIDTH+1:0]   limit;
`endif

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data;

    always_comb begin
        state_d    = state_q;
        cfg_len_d  = cfg_len_q;
        cfg_mode_d = cfg_mode_q;
        len_d      = len_q;
        mode_d     = mode_q;
        lev_d      = lev_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        idone_d    = 1'b0;
        beat_acc   = s_axi_valid & s_ready_q;
        tid_sel    = (32'(s_axi_tid) < NUM_CH) ? s_axi_tid : '0;
        cfg_idx    = cfg_data[22:17];
`ifdef FFT_CTRL_LEN_CHK_EN
        err_d      = 1'b0;
        cnt_nxt    = {1'b0, cnt_q} + 1'b1;
        limit      = (len_q == '0) ? (LEN_WIDTH+2)'(1) << LEN_WIDTH : {2'b00, len_q};
`endif
        case (state_q)
            S_IDLE: begin
                if (s_axi_valid) begin
                    state_d = S_LOAD;
                    len_d   = cfg_len_q[tid_sel];
                    mode_d  = cfg_mode_q[tid_sel];
                    lev_d   = lev_of(cfg_len_q[tid_sel]);
                    ch_d    = tid_sel;
                    cnt_d   = '0;
                end else if (cfg_valid) begin
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_valid && cfg_ready_q && (32'(cfg_idx) < NUM_CH)) begin
                    cfg_len_d[cfg_idx[CH_W-1:0]]  = cfg_data[LEN_WIDTH-1:0];
                    cfg_mode_d[cfg_idx[CH_W-1:0]] = cfg_data[16];
                end
                state_d = S_IDLE;
            end
            S_LOAD: begin
                if (beat_acc) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (s_axi_last) begin
                        state_d = S_CALC;
                        idone_d = 1'b1;
`ifdef FFT_CTRL_LEN_CHK_EN
                        err_d   = (cnt_nxt != limit);
                    end else if (cnt_nxt == limit) begin
                        // frame reached its configured length without last: truncate
                        state_d = S_CALC;
                        idone_d = 1'b1;
                        err_d   = 1'b1;
`endif
                    end
                end
            end
            S_CALC: if (fft_cdone) state_d = S_OUT;
            S_OUT:  if (fft_odone) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cfg_ready_d = (state_d == S_CFG);
        s_ready_d   = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD) || (state_d == S_CALC) || (state_d == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_len_q[i]  <= RST_LEN;
                cfg_mode_q[i] <= RST_MODE;
            end
            len_q       <= RST_LEN;
            mode_q      <= RST_MODE;
            lev_q       <= RST_LEV;
            ch_q        <= '0;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            idone_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FFT_CTRL_LEN_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_len_q   <= cfg_len_d;
            cfg_mode_q  <= cfg_mode_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            lev_q       <= lev_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= cfg_ready_d;
            s_ready_q   <= s_ready_d;
            idone_q     <= idone_d;
            busy_q      <= busy_d;
`ifdef FFT_CTRL_LEN_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign s_axi_ready   = s_ready_q;
    assign dft_mode      = mode_q;
    assign dft_length    = len_q;
    assign fft_lev_limit = lev_q;
    assign fft_ch        = ch_q;
    assign fft_idone     = idone_q;
    assign busy          = busy_q;
`ifdef FFT_CTRL_LEN_CHK_EN
    assign len_err       = err_q;
`endif

endmodule
